// File: rtl/ws_video_timing.sv
// ----------------------------------------------------------------------------
// ws_video_timing
//   Raster timing generator for the HDMI output path. Produces DE/HSYNC/VSYNC
//   and raster coordinates, maps every raster pixel onto a WonderSwan source
//   pixel (integer upscale, centred in the active area), and requests a
//   source-line fetch during horizontal blanking ahead of each new source line.
//
// Ports
//   clk          in   pixel clock
//   rst_n        in   asynchronous active-low reset
//   de           out  active-video enable
//   hsync/vsync  out  sync pulses, active level set by SYNC_POL
//   x / y        out  raster column / line
//   src_de       out  pixel lies inside the scaled source window
//   src_x/src_y  out  source column / line (meaningful only while src_de=1)
//   frame_start  out  one-cycle pulse with raster (0,0)
//   line_req     out  one-cycle line-fetch request at the first blanking clock
//   line_req_y   out  source line to fetch, valid while line_req=1
//
// All outputs are registered together; they describe the counter position that
// held before the clock edge, so x/y trail the internal h/v counters by one.
// ----------------------------------------------------------------------------
module ws_video_timing #(
  parameter int FRAMEWIDTH  = 1280,
  parameter int FRAMEHEIGHT = 720,
  parameter int TOTALWIDTH  = 1650,
  parameter int TOTALHEIGHT = 750,
  parameter int HFP         = 110,
  parameter int HSW         = 40,
  parameter int VFP         = 5,
  parameter int VSW         = 5,
  parameter int SYNC_POL    = 1,
  parameter int SCALE       = 5,
  parameter int SRC_W       = 224,
  parameter int SRC_H       = 144,
  parameter int XW          = $clog2(TOTALWIDTH),
  parameter int YW          = $clog2(TOTALHEIGHT)
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic          de,
  output logic          hsync,
  output logic          vsync,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          src_de,
  output logic [7:0]    src_x,
  output logic [7:0]    src_y,
  output logic          frame_start,
  output logic          line_req,
  output logic [7:0]    line_req_y
);

  localparam int XOFF = (FRAMEWIDTH - SRC_W * SCALE) / 2;
  localparam int YOFF = (FRAMEHEIGHT - SRC_H * SCALE) / 2;
  localparam int XEND = XOFF + SRC_W * SCALE;
  localparam int YEND = YOFF + SRC_H * SCALE;
  localparam int HS_BEG = FRAMEWIDTH + HFP;
  localparam int HS_END = FRAMEWIDTH + HFP + HSW;
  localparam int VS_BEG = FRAMEHEIGHT + VFP;
  localparam int VS_END = FRAMEHEIGHT + VFP + VSW;
  localparam int PW = (SCALE > 1) ? $clog2(SCALE) : 1;
  localparam logic [PW-1:0] PH_LAST = PW'(SCALE - 1);
  localparam logic SYNC_ON  = (SYNC_POL != 0);
  localparam logic SYNC_OFF = ~SYNC_ON;

  if (SRC_W * SCALE > FRAMEWIDTH || SRC_H * SCALE > FRAMEHEIGHT) begin : g_bad_geometry
    $error("ws_video_timing: scaled source does not fit inside the active frame");
  end

  // Raster counters and source-mapping phase state
  logic [XW-1:0] h_q, h_d;
  logic [YW-1:0] v_q, v_d;
  logic [PW-1:0] hph_q, hph_d, vph_q, vph_d;
  logic [7:0]    sxc_q, sxc_d, syc_q, syc_d;

  // Registered outputs
  logic          de_q, de_d;
  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic          src_de_q, src_de_d;
  logic [7:0]    src_x_q, src_x_d;
  logic [7:0]    src_y_q, src_y_d;
  logic          frame_start_q, frame_start_d;
  logic          line_req_q, line_req_d;
  logic [7:0]    line_req_y_q, line_req_y_d;

  // 32-bit views so every geometry comparison is free of width truncation
  logic [31:0] hw, vw, hn_w, vnext_w;
  logic        h_wrap, v_wrap, in_win, next_in_win;
  logic [7:0]  req_idx;

  always_comb begin
    hw     = 32'(h_q);
    vw     = 32'(v_q);
    h_wrap = (hw == TOTALWIDTH - 1);
    v_wrap = (vw == TOTALHEIGHT - 1);

    h_d = h_wrap ? '0 : h_q + XW'(1);
    v_d = v_q;
    if (h_wrap) v_d = v_wrap ? '0 : v_q + YW'(1);
    hn_w = 32'(h_d);

    // Horizontal phase tracks the pixel held in h; it is set up one clock
    // early from h_d so src_x lines up with the registered raster outputs.
    hph_d = hph_q;
    sxc_d = sxc_q;
    if (hn_w == XOFF) begin
      hph_d = '0;
      sxc_d = '0;
    end else if (hn_w > XOFF && hn_w < XEND) begin
      if (hph_q == PH_LAST) begin
        hph_d = '0;
        sxc_d = sxc_q + 8'd1;
      end else begin
        hph_d = hph_q + PW'(1);
      end
    end

    // Vertical phase steps once per line, only between two window rows, so it
    // idles at zero above the window and holds below it until the frame wraps.
    vnext_w = v_wrap ? 32'd0 : vw + 32'd1;
    vph_d   = vph_q;
    syc_d   = syc_q;
    if (h_wrap) begin
      if (v_wrap) begin
        vph_d = '0;
        syc_d = '0;
      end else if (vw >= YOFF && vnext_w < YEND) begin
        if (vph_q == PH_LAST) begin
          vph_d = '0;
          syc_d = syc_q + 8'd1;
        end else begin
          vph_d = vph_q + PW'(1);
        end
      end
    end

    // Next line starts a new source line when it is the first window row or
    // when the current row is the last replica of its source line.
    next_in_win = (vnext_w >= YOFF) && (vnext_w < YEND);
    req_idx     = (vnext_w == YOFF) ? 8'd0 : syc_q + 8'd1;

    // Output decode from the pre-edge counter position
    x_d           = h_q;
    y_d           = v_q;
    de_d          = (hw < FRAMEWIDTH) && (vw < FRAMEHEIGHT);
    hsync_d       = (hw >= HS_BEG && hw < HS_END) ? SYNC_ON : SYNC_OFF;
    vsync_d       = (vw >= VS_BEG && vw < VS_END) ? SYNC_ON : SYNC_OFF;
    in_win        = de_d && (hw >= XOFF) && (hw < XEND) && (vw >= YOFF) && (vw < YEND);
    src_de_d      = in_win;
    src_x_d       = in_win ? sxc_q : src_x_q;
    src_y_d       = in_win ? syc_q : src_y_q;
    frame_start_d = (hw == 32'd0) && (vw == 32'd0);
    line_req_d    = (hw == FRAMEWIDTH) && next_in_win &&
                    ((vnext_w == YOFF) || (vph_q == PH_LAST));
    line_req_y_d  = line_req_d ? req_idx : line_req_y_q;
  end

  // Register stage: counters, phases and every output
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_q           <= '0;
      v_q           <= '0;
      hph_q         <= '0;
      vph_q         <= '0;
      sxc_q         <= '0;
      syc_q         <= '0;
      de_q          <= 1'b0;
      hsync_q       <= SYNC_OFF;
      vsync_q       <= SYNC_OFF;
      x_q           <= '0;
      y_q           <= '0;
      src_de_q      <= 1'b0;
      src_x_q       <= '0;
      src_y_q       <= '0;
      frame_start_q <= 1'b0;
      line_req_q    <= 1'b0;
      line_req_y_q  <= '0;
    end else begin
      h_q           <= h_d;
      v_q           <= v_d;
      hph_q         <= hph_d;
      vph_q         <= vph_d;
      sxc_q         <= sxc_d;
      syc_q         <= syc_d;
      de_q          <= de_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      x_q           <= x_d;
      y_q           <= y_d;
      src_de_q      <= src_de_d;
      src_x_q       <= src_x_d;
      src_y_q       <= src_y_d;
      frame_start_q <= frame_start_d;
      line_req_q    <= line_req_d;
      line_req_y_q  <= line_req_y_d;
    end
  end

  assign de          = de_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign x           = x_q;
  assign y           = y_q;
  assign src_de      = src_de_q;
  assign src_x       = src_x_q;
  assign src_y       = src_y_q;
  assign frame_start = frame_start_q;
  assign line_req    = line_req_q;
  assign line_req_y  = line_req_y_q;

endmodule

// File: tb/tb_ws_video_timing.sv
// ----------------------------------------------------------------------------
// tb_ws_video_timing
//   Bench for ws_video_timing on a reduced raster (30x18 total, 20x12 active,
//   8x5 source at scale 2) so whole frames fit in a short run. Offsets for this
//   geometry: XOFF=2, YOFF=1. A reference model built on division pushes the
//   expected outputs for every clock edge; they are popped and compared on the
//   following falling edge. A coordinate-keyed vector table, frame statistics
//   and a mid-frame reset sequence cover the corner cases.
// ----------------------------------------------------------------------------
module tb_ws_video_timing;

  localparam int FW = 20, FH = 12, TW = 30, TH = 18;
  localparam int HFP = 3, HSW = 4, VFP = 2, VSW = 2;
  localparam int SC = 2, SW = 8, SH = 5;
  localparam int XO = 2, YO = 1;
  localparam int FRAME = TW * TH;   // 540 clocks

  logic       clk = 1'b0;
  logic       rst_n;
  logic       de, hsync, vsync, src_de, frame_start, line_req;
  logic [4:0] x, y;
  logic [7:0] src_x, src_y, line_req_y;

  ws_video_timing #(
    .FRAMEWIDTH(FW), .FRAMEHEIGHT(FH), .TOTALWIDTH(TW), .TOTALHEIGHT(TH),
    .HFP(HFP), .HSW(HSW), .VFP(VFP), .VSW(VSW), .SYNC_POL(1),
    .SCALE(SC), .SRC_W(SW), .SRC_H(SH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .de(de), .hsync(hsync), .vsync(vsync),
    .x(x), .y(y), .src_de(src_de), .src_x(src_x), .src_y(src_y),
    .frame_start(frame_start), .line_req(line_req), .line_req_y(line_req_y)
  );

  always #5 clk = ~clk;

  typedef struct {
    int   x, y;
    logic de, hs, vs, fs, sde;
    int   sx, sy;
    logic lr;
    int   lry;
    logic strict;
  } exp_t;

  int   checks = 0;
  int   errors = 0;
  int   mp     = 0;
  exp_t sbq[$];
  exp_t tbl[26];

  function automatic exp_t mk(int ex, int ey, logic ede, logic ehs, logic evs, logic efs,
                              logic esde, int esx, int esy, logic elr, int elry);
    exp_t e;
    e.x = ex; e.y = ey; e.de = ede; e.hs = ehs; e.vs = evs; e.fs = efs;
    e.sde = esde; e.sx = esx; e.sy = esy; e.lr = elr; e.lry = elry; e.strict = 1'b0;
    return e;
  endfunction

  function automatic exp_t reset_exp();
    exp_t e = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    e.strict = 1'b1;
    return e;
  endfunction

  function automatic exp_t model(int p);
    exp_t e;
    int px = p % TW;
    int py = p / TW;
    int yn = (py == TH - 1) ? 0 : py + 1;
    e.x   = px;
    e.y   = py;
    e.de  = (px < FW) && (py < FH);
    e.hs  = (px >= FW + HFP) && (px < FW + HFP + HSW);
    e.vs  = (py >= FH + VFP) && (py < FH + VFP + VSW);
    e.fs  = (p == 0);
    e.sde = e.de && (px >= XO) && (px < XO + SW * SC) && (py >= YO) && (py < YO + SH * SC);
    e.sx  = (px - XO) / SC;
    e.sy  = (py - YO) / SC;
    e.lr  = (px == FW) && (yn >= YO) && (yn < YO + SH * SC) && ((yn - YO) % SC == 0);
    e.lry = (yn - YO) / SC;
    e.strict = 1'b0;
    return e;
  endfunction

  task automatic cmp(input string nm, input exp_t e);
    logic ok;
    ok = (de === e.de) && (hsync === e.hs) && (vsync === e.vs) &&
         (frame_start === e.fs) && (src_de === e.sde) && (line_req === e.lr) &&
         (int'(x) == e.x) && (int'(y) == e.y);
    if (e.strict || e.sde) ok = ok && (int'(src_x) == e.sx) && (int'(src_y) == e.sy);
    if (e.strict || e.lr)  ok = ok && (int'(line_req_y) == e.lry);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got x=%0d y=%0d de=%b hs=%b vs=%b fs=%b sde=%b sx=%0d sy=%0d lr=%b lry=%0d ; want x=%0d y=%0d de=%b hs=%b vs=%b fs=%b sde=%b sx=%0d sy=%0d lr=%b lry=%0d",
               nm, x, y, de, hsync, vsync, frame_start, src_de, src_x, src_y, line_req, line_req_y,
               e.x, e.y, e.de, e.hs, e.vs, e.fs, e.sde, e.sx, e.sy, e.lr, e.lry);
    end
  endtask

  task automatic check_int(input string nm, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", nm, got, want);
    end
  endtask

  // One clock: push the expectation for this edge, compare on the falling edge
  task automatic tick();
    exp_t e;
    @(posedge clk);
    if (!rst_n) begin
      mp = 0;
      sbq.push_back(reset_exp());
    end else begin
      sbq.push_back(model(mp));
      mp = (mp + 1) % FRAME;
    end
    @(negedge clk);
    if (sbq.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard: queue empty");
    end else begin
      e = sbq.pop_front();
      cmp("scoreboard", e);
    end
  endtask

  task automatic wait_xy(input int wx, input int wy, input string nm, output logic hit);
    int n = 0;
    while (!(int'(x) == wx && int'(y) == wy) && n < FRAME + 5) begin
      tick();
      n++;
    end
    hit = (n < FRAME + 5);
    if (!hit) check_int({nm, "_timeout"}, n, 0);
  endtask

  initial begin
    logic hit;
    int   n, c_de, c_hs, c_vs, c_sde, c_lr;

    tbl[0]  = mk( 0,  0, 1, 0, 0, 1, 0, 0, 0, 0, 0);
    tbl[1]  = mk( 2,  0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[2]  = mk(19,  0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[3]  = mk(20,  0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    tbl[4]  = mk(23,  0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    tbl[5]  = mk(26,  0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    tbl[6]  = mk(27,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[7]  = mk( 1,  1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[8]  = mk( 2,  1, 1, 0, 0, 0, 1, 0, 0, 0, 0);
    tbl[9]  = mk( 3,  1, 1, 0, 0, 0, 1, 0, 0, 0, 0);
    tbl[10] = mk( 4,  1, 1, 0, 0, 0, 1, 1, 0, 0, 0);
    tbl[11] = mk(17,  1, 1, 0, 0, 0, 1, 7, 0, 0, 0);
    tbl[12] = mk(18,  1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[13] = mk(20,  2, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    tbl[14] = mk( 2,  3, 1, 0, 0, 0, 1, 0, 1, 0, 0);
    tbl[15] = mk(20,  8, 0, 0, 0, 0, 0, 0, 0, 1, 4);
    tbl[16] = mk(17, 10, 1, 0, 0, 0, 1, 7, 4, 0, 0);
    tbl[17] = mk(20, 10, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[18] = mk( 2, 11, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[19] = mk( 0, 12, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[20] = mk(29, 13, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[21] = mk( 0, 14, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    tbl[22] = mk(24, 14, 0, 1, 1, 0, 0, 0, 0, 0, 0);
    tbl[23] = mk(29, 15, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    tbl[24] = mk( 0, 16, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[25] = mk(20, 17, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    rst_n = 1'b0;
    repeat (3) tick();
    #1 rst_n = 1'b1;
    tick();

    // Coordinate-keyed vectors across the first frame
    foreach (tbl[i]) begin
      wait_xy(tbl[i].x, tbl[i].y, $sformatf("vec%0d", i), hit);
      if (hit) cmp($sformatf("vec%0d", i), tbl[i]);
    end

    // Full-frame statistics between consecutive frame_start pulses
    n = 0;
    while (frame_start !== 1'b1 && n < FRAME + 5) begin tick(); n++; end
    check_int("fs_found", (n < FRAME + 5) ? 1 : 0, 1);
    c_de = 0; c_hs = 0; c_vs = 0; c_sde = 0; c_lr = 0;
    n = 0;
    do begin
      c_de  += int'(de);
      c_hs  += int'(hsync);
      c_vs  += int'(vsync);
      c_sde += int'(src_de);
      c_lr  += int'(line_req);
      tick();
      n++;
    end while (frame_start !== 1'b1 && n < FRAME + 5);
    check_int("frame_period", n, FRAME);
    check_int("de_count", c_de, FW * FH);
    check_int("hsync_count", c_hs, HSW * TH);
    check_int("vsync_count", c_vs, VSW * TW);
    check_int("src_de_count", c_sde, SW * SC * SH * SC);
    check_int("line_req_count", c_lr, SH);

    // Mid-frame reset: outputs drop at once, restart cleanly at (0,0)
    wait_xy(10, 6, "rst_point", hit);
    #1 rst_n = 1'b0;
    #1 cmp("rst_async", reset_exp());
    repeat (3) tick();
    #1 rst_n = 1'b1;
    tick();
    cmp("rst_first_edge", model(0));
    n = 0;
    do begin tick(); n++; end while (frame_start !== 1'b1 && n < FRAME + 5);
    check_int("rst_frame_period", n, FRAME);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ws_video_timing.md
Name: ws_video_timing

Overview:
- Raster timing generator for the HDMI output path. Produces DE, HSYNC and VSYNC, plus the raster pixel coordinates, for the frame geometry defined by configPackage.
- Maps each raster pixel to a WonderSwan source pixel, with integer scaling and centring, for the line-buffer/pixel-fetch stage that follows it.
- Issues a one-cycle line-fetch request during horizontal blanking ahead of every new source line.
- Runs on the pixel clock; sits between the PLL/clock block and the TMDS/HDMI packetiser.

Parameters:
- FRAMEWIDTH, 1280, active pixels per line
- FRAMEHEIGHT, 720, active lines
- TOTALWIDTH, 1650, total clocks per line
- TOTALHEIGHT, 750, total lines per frame
- HFP, 110, horizontal front porch in clocks
- HSW, 40, hsync width in clocks
- VFP, 5, vertical front porch in lines
- VSW, 5, vsync width in lines
- SYNC_POL, 1, 1 = sync pulses active-high
- SCALE, 5, integer upscale factor
- SRC_W, 224, source pixels per line
- SRC_H, 144, source lines
- XW/YW, $clog2(TOTALWIDTH)/$clog2(TOTALHEIGHT), counter widths (derived)

Ports:
- clk  in  1  pixel clock (74.25 MHz at 720p)
- rst_n  in  1  asynchronous active-low reset
- de  out  1  active-video enable
- hsync  out  1  horizontal sync, polarity per SYNC_POL
- vsync  out  1  vertical sync, polarity per SYNC_POL
- x  out  XW  raster column
- y  out  YW  raster line
- src_de  out  1  raster pixel lies inside the scaled source window
- src_x  out  8  source column 0..SRC_W-1
- src_y  out  8  source line 0..SRC_H-1
- frame_start  out  1  one-cycle pulse with raster (0,0)
- line_req  out  1  one-cycle fetch request
- line_req_y  out  8  source line to fetch; valid while line_req=1

Behaviour:
- Offsets: XOFF=(FRAMEWIDTH-SRC_W*SCALE)/2 and YOFF=(FRAMEHEIGHT-SRC_H*SCALE)/2, computed at elaboration. At the defaults these are 80 and 0.
- Elaboration error if SRC_W*SCALE>FRAMEWIDTH or SRC_H*SCALE>FRAMEHEIGHT.
- Internal counters h (0..TOTALWIDTH-1) and v (0..TOTALHEIGHT-1).
  - h increments every clock.
  - At h=TOTALWIDTH-1, h wraps to 0 and v increments; at v=TOTALHEIGHT-1, v wraps to 0.
- All outputs are registered and mutually aligned. Each clock, outputs reflect the counter value that held before that edge, so x/y lag h/v by 1 clock.
- Output decode:
  - de = (x<FRAMEWIDTH) && (y<FRAMEHEIGHT).
  - hsync active for x in [FRAMEWIDTH+HFP, FRAMEWIDTH+HFP+HSW).
  - vsync active for whole lines y in [FRAMEHEIGHT+VFP, FRAMEHEIGHT+VFP+VSW), aligned to x=0, not to the hsync edge.
- Source mapping uses phase counters only; no divider or multiplier.
  - hphase runs 0..SCALE-1. It is cleared at x=XOFF. When it wraps, src_x increments.
  - vphase advances once per line at h wrap, only while inside the window rows. When it wraps, src_y increments. Both clear at frame wrap.
  - src_de = de && XOFF<=x<XOFF+SRC_W*SCALE && YOFF<=y<YOFF+SRC_H*SCALE.
  - src_x/src_y hold their last value outside the window; they carry no meaning while src_de=0.
- frame_start = 1 exactly when x=0 and y=0.
- line_req:
  - Pulses for one clock at x=FRAMEWIDTH (first blanking clock) on line y when line y+1 (wrapping TOTALHEIGHT-1 to 0) is a window row with vphase=0.
  - line_req_y is the source index of that next line.
  - Exactly SRC_H pulses per frame.
  - The downstream stage has HFP+HSW+back-porch clocks to complete the fetch; there is no backpressure.
- Reset (async assert, sync release through the shared reset synchroniser):
  - de=0, hsync=vsync=inactive level, x=y=0, src_de=0, src_x=src_y=0, frame_start=0, line_req=0, line_req_y=0.
  - Counters and phases are cleared.
  - First edge after release presents (0,0) with frame_start=1 and de=1.
- Reset mid-frame abandons the current frame immediately; no partial sync pulse is stretched.

Test Plan:
- Defaults, release reset, run 2 frames -> frame_start period exactly 1,237,500 clocks; de high for 1280 clocks per line on lines 0..719 only.
- Sync check -> hsync high for x=1390..1429 (40 clocks), every line; vsync high for lines 725..729 from x=0 through x=1649 of line 729.
- Horizontal mapping on y=0:
  - src_de rises at x=80 with src_x=0.
  - src_x=1 at x=85.
  - src_x=223 at x=1195..1199.
  - src_de=0 at x=1200.
- Vertical mapping:
  - src_y=0 on lines 0..4, src_y=1 on line 5, src_y=143 on lines 715..719.
  - line_req at x=1280 of line 4 with line_req_y=1.
  - line_req at x=1280 of line 749 with line_req_y=0.
  - 144 pulses per frame.
- Assert rst_n low at (x=600,y=300) for 3 clocks -> all outputs hold their reset values while low, including during the low phase. After release: frame_start=1 at the first edge, and the next frame_start follows exactly 1,237,500 clocks later.
- SCALE=3, FRAMEWIDTH=720, FRAMEHEIGHT=480, TOTALWIDTH=858, TOTALHEIGHT=525 -> XOFF=24, YOFF=24; src_de rises at (24,24); frame period 450,450 clocks.
